// File: rtl/bist_pkg.sv
// Shared BIST definitions: compactor FSM states, default MISR geometry and
// the Galois MISR next-state function used by RTL and bench alike.
package bist_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPACT = 2'd1,
    CHECK   = 2'd2,
    RESULT  = 2'd3
  } state_t;

  localparam int unsigned MAX_WIDTH = 32;
  localparam int unsigned DEF_WIDTH = 8;
  localparam logic [7:0]  DEF_POLY  = 8'hB8;

  // Operands are zero-extended to MAX_WIDTH; width selects the live bits.
  function automatic logic [MAX_WIDTH-1:0] misr_next(
    input logic [MAX_WIDTH-1:0] sig,
    input logic [MAX_WIDTH-1:0] data,
    input logic [MAX_WIDTH-1:0] poly,
    input int unsigned          width
  );
    logic [MAX_WIDTH-1:0] mask;
    logic [MAX_WIDTH-1:0] fb;
    mask = (width >= MAX_WIDTH) ? '1 : ((MAX_WIDTH'(1) << width) - MAX_WIDTH'(1));
    fb   = (((sig >> (width - 1)) & MAX_WIDTH'(1)) != '0) ? poly : '0;
    return ((sig << 1) ^ fb ^ data) & mask;
  endfunction

endpackage

// File: rtl/misr_compactor_misr_reg.sv
// WIDTH-bit multiple-input signature register; load_seed together with
// enable folds the word into SEED rather than the current signature.
module misr_reg
  import bist_pkg::*;
#(
  parameter int unsigned      WIDTH = DEF_WIDTH,
  parameter logic [WIDTH-1:0] POLY  = WIDTH'(DEF_POLY),
  parameter logic [WIDTH-1:0] SEED  = '0
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             load_seed,
  input  logic             enable,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] sig
);

  logic [WIDTH-1:0] base;
  logic [WIDTH-1:0] upd;

  assign base = load_seed ? SEED : sig;
  assign upd  = WIDTH'(misr_next(MAX_WIDTH'(base), MAX_WIDTH'(data_in),
                                 MAX_WIDTH'(POLY), WIDTH));

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET)         sig <= SEED;
    else if (enable)    sig <= upd;
    else if (load_seed) sig <= SEED;
  end

endmodule

// File: rtl/misr_compactor.sv
// BIST output-response compactor: MISR folding plus PASS/FAIL verdict.
// Define MISR_CYCLE_COUNT_EN to add the COUNT port and cycle-count check.
module misr_compactor
  import bist_pkg::*;
#(
  parameter int unsigned      WIDTH  = DEF_WIDTH,
  parameter logic [WIDTH-1:0] POLY   = WIDTH'(DEF_POLY),
  parameter logic [WIDTH-1:0] SEED   = '0,
  parameter logic [WIDTH-1:0] GOLDEN = '0
`ifdef MISR_CYCLE_COUNT_EN
  ,
  parameter int unsigned      EXP_CYCLES = 81
`endif
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             ENABLE,
  input  logic             RUNNING,
  input  logic             BIST_END,
  input  logic [WIDTH-1:0] DATA_IN,
  input  logic             ACK,
  output logic [WIDTH-1:0] SIGNATURE,
`ifdef MISR_CYCLE_COUNT_EN
  output logic [7:0]       COUNT,
`endif
  output logic             DONE,
  output logic             PASS,
  output logic             FAIL
);

  state_t state, state_nxt;
  logic   load_seed;
  logic   compact_en;
  logic   set_verdict;
  logic   clr_verdict;
  logic   match;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state <= IDLE;
    else        state <= state_nxt;
  end

  // load_seed with compact_en starts a session by folding the first word into SEED.
  always_comb begin
    state_nxt   = state;
    load_seed   = 1'b0;
    compact_en  = 1'b0;
    set_verdict = 1'b0;
    clr_verdict = 1'b0;
    case (state)
      IDLE: begin
        load_seed = 1'b1;
        if (RUNNING) begin
          state_nxt  = COMPACT;
          compact_en = ENABLE;
        end
      end
      COMPACT: begin
        if (BIST_END) begin
          state_nxt = CHECK;
        end else if (!RUNNING) begin
          state_nxt = IDLE;
          load_seed = 1'b1;
        end else begin
          compact_en = ENABLE;
        end
      end
      CHECK: begin
        set_verdict = 1'b1;
        state_nxt   = RESULT;
      end
      RESULT: begin
        if (RUNNING) begin
          state_nxt   = COMPACT;
          load_seed   = 1'b1;
          compact_en  = ENABLE;
          clr_verdict = 1'b1;
        end else if (ACK) begin
          state_nxt   = IDLE;
          load_seed   = 1'b1;
          clr_verdict = 1'b1;
        end
      end
      default: begin
        state_nxt   = IDLE;
        load_seed   = 1'b1;
        clr_verdict = 1'b1;
      end
    endcase
  end

  misr_reg #(
    .WIDTH (WIDTH),
    .POLY  (POLY),
    .SEED  (SEED)
  ) u_misr (
    .CLK       (CLK),
    .RESET     (RESET),
    .load_seed (load_seed),
    .enable    (compact_en),
    .data_in   (DATA_IN),
    .sig       (SIGNATURE)
  );

`ifdef MISR_CYCLE_COUNT_EN
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET)                          COUNT <= '0;
    else if (load_seed)                  COUNT <= compact_en ? 8'd1 : 8'd0;
    else if (compact_en && COUNT != '1)  COUNT <= COUNT + 8'd1;
  end

  assign match = (SIGNATURE == GOLDEN) && (COUNT == 8'(EXP_CYCLES));
`else
  assign match = (SIGNATURE == GOLDEN);
`endif

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      DONE <= 1'b0;
      PASS <= 1'b0;
      FAIL <= 1'b0;
    end else if (set_verdict) begin
      DONE <= 1'b1;
      PASS <= match;
      FAIL <= !match;
    end else if (clr_verdict) begin
      DONE <= 1'b0;
      PASS <= 1'b0;
      FAIL <= 1'b0;
    end
  end

endmodule

// File: tb/tb_misr_compactor.sv
// Self-checking bench for misr_compactor (WIDTH=4, POLY=3, SEED=0, GOLDEN=3):
// session-level reference model compared every cycle, plus literal expectations.
module tb_misr_compactor;

  logic       CLK = 1'b0;
  logic       RESET = 1'b0;
  logic       ENABLE = 1'b0;
  logic       RUNNING = 1'b0;
  logic       BIST_END = 1'b0;
  logic [3:0] DATA_IN = '0;
  logic       ACK = 1'b0;
  logic [3:0] SIGNATURE;
  logic       DONE, PASS, FAIL;
`ifdef MISR_CYCLE_COUNT_EN
  logic [7:0] COUNT;
`endif

  int checks = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  misr_compactor #(
    .WIDTH  (4),
    .POLY   (4'h3),
    .SEED   (4'h0),
    .GOLDEN (4'h3)
`ifdef MISR_CYCLE_COUNT_EN
    ,
    .EXP_CYCLES (81)
`endif
  ) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .ENABLE    (ENABLE),
    .RUNNING   (RUNNING),
    .BIST_END  (BIST_END),
    .DATA_IN   (DATA_IN),
    .ACK       (ACK),
    .SIGNATURE (SIGNATURE),
`ifdef MISR_CYCLE_COUNT_EN
    .COUNT     (COUNT),
`endif
    .DONE      (DONE),
    .PASS      (PASS),
    .FAIL      (FAIL)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: 0 = no session, 1 = collecting, 2 = judging, 3 = verdict held.
  int         m_mode = 0;
  logic [3:0] m_sig = 4'h0;
  int         m_cnt = 0;
  logic       m_done = 1'b0, m_pass = 1'b0, m_fail = 1'b0;
  logic       m_ok;

  function automatic logic [3:0] fold(input logic [3:0] s, input logic [3:0] d);
    int v;
    v = (int'(s) * 2) % 16;
    if (int'(s) >= 8) v = v ^ 3;
    v = v ^ int'(d);
    return 4'(v);
  endfunction

`ifdef MISR_CYCLE_COUNT_EN
  assign m_ok = (m_sig == 4'h3) && (m_cnt == 81);
`else
  assign m_ok = (m_sig == 4'h3);
`endif

  always @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      m_mode <= 0; m_sig <= 4'h0; m_cnt <= 0;
      m_done <= 1'b0; m_pass <= 1'b0; m_fail <= 1'b0;
    end else begin
      case (m_mode)
        0: if (RUNNING) begin
          m_mode <= 1;
          m_sig  <= ENABLE ? fold(4'h0, DATA_IN) : 4'h0;
          m_cnt  <= ENABLE ? 1 : 0;
        end
        1: if (BIST_END) m_mode <= 2;
           else if (!RUNNING) begin
             m_mode <= 0; m_sig <= 4'h0; m_cnt <= 0;
           end else if (ENABLE) begin
             m_sig <= fold(m_sig, DATA_IN);
             m_cnt <= (m_cnt < 255) ? m_cnt + 1 : 255;
           end
        2: begin
          m_mode <= 3; m_done <= 1'b1; m_pass <= m_ok; m_fail <= !m_ok;
        end
        default: if (RUNNING) begin
          m_mode <= 1;
          m_done <= 1'b0; m_pass <= 1'b0; m_fail <= 1'b0;
          m_sig  <= ENABLE ? fold(4'h0, DATA_IN) : 4'h0;
          m_cnt  <= ENABLE ? 1 : 0;
        end else if (ACK) begin
          m_mode <= 0; m_sig <= 4'h0; m_cnt <= 0;
          m_done <= 1'b0; m_pass <= 1'b0; m_fail <= 1'b0;
        end
      endcase
    end
  end

  always @(negedge CLK) begin
    chk("sig_model",  int'(SIGNATURE), int'(m_sig));
    chk("done_model", int'(DONE), int'(m_done));
    chk("pass_model", int'(PASS), int'(m_pass));
    chk("fail_model", int'(FAIL), int'(m_fail));
    chk("pass_fail_excl", int'(PASS & FAIL), 0);
`ifdef MISR_CYCLE_COUNT_EN
    chk("count_model", int'(COUNT), m_cnt);
`endif
  end

  task automatic step(input logic run, input logic en, input logic be,
                      input logic ak, input logic [3:0] d);
    @(negedge CLK);
    RUNNING = run; ENABLE = en; BIST_END = be; ACK = ak; DATA_IN = d;
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
  endtask

  initial begin
    repeat (2) @(negedge CLK);
    chk("reset_sig", int'(SIGNATURE), 0);
    chk("reset_done", int'(DONE), 0);
    RESET = 1'b1;
    idle();

    // Passing session: 8 then 0 folds to 8 then 3 == GOLDEN
    step(1'b1, 1'b1, 1'b0, 1'b0, 4'h8);
    chk("a_sig1", int'(SIGNATURE), 8);
    step(1'b1, 1'b1, 1'b0, 1'b0, 4'h0);
    chk("a_sig2", int'(SIGNATURE), 3);
    step(1'b1, 1'b0, 1'b1, 1'b0, 4'h0);
    chk("a_done_early", int'(DONE), 0);
    idle();
    chk("a_done", int'(DONE), 1);
    chk("a_pass", int'(PASS), 1);
    repeat (3) idle();
    chk("a_held", int'({DONE, PASS, FAIL}), 3'b110);
    step(1'b0, 1'b0, 1'b0, 1'b1, 4'h0);
    chk("a_ack", int'({DONE, PASS, FAIL}), 0);

    // Failing session; the word offered in the BIST_END cycle is ignored
    step(1'b1, 1'b1, 1'b0, 1'b0, 4'h1);
    chk("b_sig1", int'(SIGNATURE), 1);
    step(1'b1, 1'b1, 1'b0, 1'b0, 4'h2);
    chk("b_sig2", int'(SIGNATURE), 0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 4'hF);
    chk("b_end_ignored", int'(SIGNATURE), 0);
    idle();
    chk("b_fail", int'({DONE, PASS, FAIL}), 3'b101);
    step(1'b0, 1'b0, 1'b0, 1'b1, 4'h0);

    // Aborted session: reseed, no verdict
    step(1'b1, 1'b1, 1'b0, 1'b0, 4'h5);
    step(1'b1, 1'b1, 1'b0, 1'b0, 4'h3);
    step(1'b1, 1'b1, 1'b0, 1'b0, 4'h7);
    chk("c_sig_pre", int'(SIGNATURE), 6);
    idle();
    chk("c_sig_seed", int'(SIGNATURE), 0);
    repeat (2) idle();
    chk("c_no_done", int'(DONE), 0);

    // Back-to-back: RUNNING with ACK out of a PASS verdict starts a new session
    step(1'b1, 1'b1, 1'b0, 1'b0, 4'h8);
    step(1'b1, 1'b1, 1'b0, 1'b0, 4'h0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 4'h0);
    idle();
    chk("d_pass", int'(PASS), 1);
    step(1'b1, 1'b1, 1'b0, 1'b1, 4'h4);
    chk("d_done_clr", int'(DONE), 0);
    chk("d_sig", int'(SIGNATURE), 4);
    step(1'b1, 1'b0, 1'b0, 1'b0, 4'h9);
    chk("d_hold", int'(SIGNATURE), 4);
    step(1'b1, 1'b0, 1'b1, 1'b0, 4'h0);
    idle();
    chk("d_fail", int'(FAIL), 1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 4'h0);

    // Asynchronous reset in the middle of a session
    step(1'b1, 1'b1, 1'b0, 1'b0, 4'h8);
    #2 RESET = 1'b0;
    #1;
    chk("e_rst_sig", int'(SIGNATURE), 0);
    chk("e_rst_flags", int'({DONE, PASS, FAIL}), 0);
    @(negedge CLK);
    RESET = 1'b1; RUNNING = 1'b0; ENABLE = 1'b0;
    idle();
    chk("e_idle_sig", int'(SIGNATURE), 0);

`ifdef MISR_CYCLE_COUNT_EN
    for (int n = 0; n < 3; n++) begin
      int zeros;
      zeros = (n == 0) ? 78 : (n == 1) ? 79 : 298;
      for (int i = 0; i < zeros; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 4'h0);
      step(1'b1, 1'b1, 1'b0, 1'b0, 4'h8);
      step(1'b1, 1'b1, 1'b0, 1'b0, 4'h0);
      step(1'b0, 1'b0, 1'b1, 1'b0, 4'h0);
      idle();
      chk("f_count", int'(COUNT), (n == 0) ? 80 : (n == 1) ? 81 : 255);
      chk("f_verdict", int'({DONE, PASS, FAIL}), (n == 1) ? 3'b110 : 3'b101);
      step(1'b0, 1'b0, 1'b0, 1'b1, 4'h0);
    end
`endif

    idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
